// File: rtl/sprite_move_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_move_arbiter_if
//  Description : Request/response and board-write bundle between the two
//                player front ends and the sprite move arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface sprite_move_arbiter_if;
    logic       frame_tick;
    logic       req1;
    logic       req2;
    logic [3:0] cell1;
    logic [3:0] cell2;
    logic       clear;
    logic       grant1;
    logic       grant2;
    logic       deny1;
    logic       deny2;
    logic       busy;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [1:0] wr_player;
    logic [9:0] anim_x;
    logic [9:0] anim_y;
    logic       anim_active;
    logic       full;

    // Driver side: players, vblank timing and board clear
    modport master (
        output frame_tick, req1, req2, cell1, cell2, clear,
        input  grant1, grant2, deny1, deny2, busy, wr_en, wr_addr, wr_player,
        input  anim_x, anim_y, anim_active, full
    );

    // Arbiter side
    modport slave (
        input  frame_tick, req1, req2, cell1, cell2, clear,
        output grant1, grant2, deny1, deny2, busy, wr_en, wr_addr, wr_player,
        output anim_x, anim_y, anim_active, full
    );
endinterface
`default_nettype wire

// File: rtl/sprite_move_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_move_arbiter
//  Description : Arbitrates two players' move requests onto a 4x4 board,
//                animates the falling sprite one step per frame and commits
//                the move to board memory. Optional macro SPRITE_ARB_RR_EN
//                selects round-robin priority (default: player 1 wins ties).
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_move_arbiter #(
    parameter logic [9:0] CELL_W = 10'd160,
    parameter logic [9:0] CELL_H = 10'd120,
    parameter logic [9:0] STEP_Y = 10'd40
) (
    input wire              clk,
    input wire              rst,
    sprite_move_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ANIM   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_mask;
    logic        r_full;
    logic [3:0]  r_cell;
    logic [1:0]  r_player;
    logic [9:0]  r_target_y;
    logic        r_grant1;
    logic        r_grant2;
    logic        r_deny1;
    logic        r_deny2;
    logic        r_busy;
    logic        r_wr_en;
    logic [3:0]  r_wr_addr;
    logic [1:0]  r_wr_player;
    logic [9:0]  r_anim_x;
    logic [9:0]  r_anim_y;
    logic        r_anim_active;
`ifdef SPRITE_ARB_RR_EN
    logic        r_prio;   // 0: player 1 holds the token, 1: player 2
`endif

    logic        w_pick2;
    logic [3:0]  w_cell;
    logic        w_blocked;
    logic [9:0]  w_start_x;
    logic [9:0]  w_target_y;
    logic [9:0]  w_next_y;
    logic [15:0] w_mask_set;

    // Winner selection and next-position arithmetic
    always_comb begin
`ifdef SPRITE_ARB_RR_EN
        w_pick2    = bus.req2 & (~bus.req1 | r_prio);
`else
        w_pick2    = bus.req2 & ~bus.req1;
`endif
        w_cell     = w_pick2 ? bus.cell2 : bus.cell1;
        w_blocked  = r_mask[w_cell] | r_full;
        w_start_x  = {8'd0, w_cell[1:0]} * CELL_W;
        w_target_y = {8'd0, w_cell[3:2]} * CELL_H;
        w_next_y   = r_anim_y + STEP_Y;
        w_mask_set = r_mask | (16'd1 << r_cell);
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mask        <= 16'd0;
            r_full        <= 1'b0;
            r_cell        <= 4'd0;
            r_player      <= 2'd0;
            r_target_y    <= 10'd0;
            r_grant1      <= 1'b0;
            r_grant2      <= 1'b0;
            r_deny1       <= 1'b0;
            r_deny2       <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= 4'd0;
            r_wr_player   <= 2'd0;
            r_anim_x      <= 10'd0;
            r_anim_y      <= 10'd0;
            r_anim_active <= 1'b0;
`ifdef SPRITE_ARB_RR_EN
            r_prio        <= 1'b0;
`endif
        end else begin
            // Response and write strobes are single-cycle pulses
            r_grant1 <= 1'b0;
            r_grant2 <= 1'b0;
            r_deny1  <= 1'b0;
            r_deny2  <= 1'b0;
            r_wr_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clear) begin
                        // Clear wins over any request in the same cycle
                        r_mask <= 16'd0;
                        r_full <= 1'b0;
                    end else if (bus.req1 | bus.req2) begin
                        if (w_blocked) begin
                            r_deny1 <= ~w_pick2;
                            r_deny2 <= w_pick2;
                        end else begin
                            r_grant1      <= ~w_pick2;
                            r_grant2      <= w_pick2;
                            r_cell        <= w_cell;
                            r_player      <= w_pick2 ? 2'd2 : 2'd1;
                            r_target_y    <= w_target_y;
                            r_anim_x      <= w_start_x;
                            r_anim_y      <= 10'd0;
                            r_anim_active <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= S_ANIM;
                        end
                    end
                end
                S_ANIM: begin
                    if (bus.frame_tick) begin
                        if (w_next_y >= r_target_y) begin
                            // Land exactly on the row; write goes out in COMMIT
                            r_anim_y    <= r_target_y;
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= r_cell;
                            r_wr_player <= r_player;
                            r_state     <= S_COMMIT;
                        end else begin
                            r_anim_y <= w_next_y;
                        end
                    end
                end
                S_COMMIT: begin
                    r_mask        <= w_mask_set;
                    r_full        <= &w_mask_set;
                    r_anim_active <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
`ifdef SPRITE_ARB_RR_EN
                    r_prio        <= ~r_prio;
`endif
                end
                default: begin
                    r_anim_active <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant1      = r_grant1;
    assign bus.grant2      = r_grant2;
    assign bus.deny1       = r_deny1;
    assign bus.deny2       = r_deny2;
    assign bus.busy        = r_busy;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_player   = r_wr_player;
    assign bus.anim_x      = r_anim_x;
    assign bus.anim_y      = r_anim_y;
    assign bus.anim_active = r_anim_active;
    assign bus.full        = r_full;

endmodule
`default_nettype wire

// File: tb/tb_sprite_move_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_move_arbiter
//  Description : Directed bench for sprite_move_arbiter with a scoreboard of
//                expected grant/deny/write events and a board-occupancy model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_move_arbiter;

    localparam int EV_GRANT = 0;
    localparam int EV_DENY  = 1;
    localparam int EV_WRITE = 2;

    typedef struct {
        int kind;
        int player;
        int addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ev_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_mask   = 16'd0;
    int          m_tok    = 1;

    sprite_move_arbiter_if bus();

    sprite_move_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_take(input int kind, input int player, input int addr);
        ev_t e;
        int  has;
        has = (sb.size() > 0) ? 1 : 0;
        chk("sb_event_expected", 16'(has), 16'd1);
        if (has == 1) begin
            e = sb.pop_front();
            chk("sb_kind", 16'(kind), 16'(e.kind));
            chk("sb_player", 16'(player), 16'(e.player));
            chk("sb_addr", 16'(addr), 16'(e.addr));
        end
    endtask

    // Response/write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.grant1 === 1'b1) sb_take(EV_GRANT, 1, 0);
        if (bus.grant2 === 1'b1) sb_take(EV_GRANT, 2, 0);
        if (bus.deny1  === 1'b1) sb_take(EV_DENY, 1, 0);
        if (bus.deny2  === 1'b1) sb_take(EV_DENY, 2, 0);
        if (bus.wr_en  === 1'b1) sb_take(EV_WRITE, int'(bus.wr_player), int'(bus.wr_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic on, input logic [3:0] c);
        if (p == 1) begin
            bus.req1  = on;
            bus.cell1 = c;
        end else begin
            bus.req2  = on;
            bus.cell2 = c;
        end
    endtask

    // Wait (bounded) for the player's grant or deny, then release its request
    task automatic wait_resp(input int p);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8 && got !== 1'b1; i++) begin
            step();
            got = (p == 1) ? (bus.grant1 | bus.deny1) : (bus.grant2 | bus.deny2);
        end
        chk("resp_seen", 16'(got), 16'd1);
        set_req(p, 1'b0, 4'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_grant1", 16'(bus.grant1), 16'd0);
        chk("rst_grant2", 16'(bus.grant2), 16'd0);
        chk("rst_deny1", 16'(bus.deny1), 16'd0);
        chk("rst_deny2", 16'(bus.deny2), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_wr_en", 16'(bus.wr_en), 16'd0);
        chk("rst_wr_addr", 16'(bus.wr_addr), 16'd0);
        chk("rst_wr_player", 16'(bus.wr_player), 16'd0);
        chk("rst_anim_x", 16'(bus.anim_x), 16'd0);
        chk("rst_anim_y", 16'(bus.anim_y), 16'd0);
        chk("rst_anim_active", 16'(bus.anim_active), 16'd0);
        chk("rst_full", 16'(bus.full), 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req1 = 1'b0; bus.req2 = 1'b0; bus.clear = 1'b0; bus.frame_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        m_mask = 16'd0;
        m_tok  = 1;
    endtask

    // Follow a granted sprite down to its row and through the commit
    task automatic run_anim(input int p, input logic [3:0] c, input logic clr_mid);
        int row;
        int k;
        row = int'(c[3:2]);
        k   = (row == 0) ? 1 : 3 * row;
        chk("anim_x_start", 16'(bus.anim_x), 16'(int'(c[1:0]) * 160));
        chk("anim_y_start", 16'(bus.anim_y), 16'd0);
        chk("anim_active_start", 16'(bus.anim_active), 16'd1);
        chk("busy_anim", 16'(bus.busy), 16'd1);
        sb.push_back('{EV_WRITE, p, int'(c)});
        for (int i = 1; i <= k; i++) begin
            if (clr_mid && i == 1) bus.clear = 1'b1;
            step();
            bus.clear = 1'b0;
            chk("anim_y_hold", 16'(bus.anim_y), 16'((i - 1) * 40));
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            chk("anim_y_tick", 16'(bus.anim_y), 16'((i < k) ? i * 40 : row * 120));
            chk("wr_en_on_land", 16'(bus.wr_en), 16'((i == k) ? 1 : 0));
        end
        step();
        chk("anim_active_end", 16'(bus.anim_active), 16'd0);
        chk("busy_end", 16'(bus.busy), 16'd0);
        chk("wr_en_end", 16'(bus.wr_en), 16'd0);
        m_mask[c] = 1'b1;
`ifdef SPRITE_ARB_RR_EN
        m_tok = 3 - m_tok;
`endif
    endtask

    task automatic move(input int p, input logic [3:0] c, input logic clr_mid);
        logic exp_deny;
        exp_deny = m_mask[c] | (m_mask == 16'hFFFF);
        sb.push_back('{exp_deny ? EV_DENY : EV_GRANT, p, 0});
        set_req(p, 1'b1, c);
        wait_resp(p);
        if (exp_deny) begin
            chk("busy_after_deny", 16'(bus.busy), 16'd0);
            step();
            chk("wr_en_after_deny", 16'(bus.wr_en), 16'd0);
            chk("busy_idle", 16'(bus.busy), 16'd0);
        end else begin
            run_anim(p, c, clr_mid);
        end
    endtask

    // Both players request together; the loser stays pending and is served next
    task automatic both(input logic [3:0] c1, input logic [3:0] c2);
        int w;
        int l;
`ifdef SPRITE_ARB_RR_EN
        w = m_tok;
`else
        w = 1;
`endif
        l = 3 - w;
        sb.push_back('{EV_GRANT, w, 0});
        set_req(1, 1'b1, c1);
        set_req(2, 1'b1, c2);
        wait_resp(w);
        run_anim(w, (w == 1) ? c1 : c2, 1'b0);
        sb.push_back('{EV_GRANT, l, 0});
        wait_resp(l);
        run_anim(l, (l == 1) ? c1 : c2, 1'b0);
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
        bus.cell1 = 4'd0; bus.cell2 = 4'd0; bus.clear = 1'b0;
        do_reset();
        chk_reset_vals();

        // Player 1 to cell 6 (row 1, col 2); clear during ANIM must be ignored
        move(1, 4'b0110, 1'b1);
        chk("full_after_one", 16'(bus.full), 16'd0);
        // Cell 6 now occupied
        move(2, 4'd6, 1'b0);
        // Row 0 lands on the first tick
        move(1, 4'd0, 1'b0);

        // Fill the board
        for (int c = 0; c < 16; c++) begin
            if (!m_mask[c]) move((c % 2) + 1, 4'(c), 1'b0);
        end
        chk("full_set", 16'(bus.full), 16'd1);
        move(2, 4'd5, 1'b0);
        move(1, 4'd9, 1'b0);

        // Clear beats a same-cycle request, which gets no response
        bus.clear = 1'b1;
        set_req(1, 1'b1, 4'd3);
        step();
        bus.clear = 1'b0;
        set_req(1, 1'b0, 4'd0);
        chk("clear_no_grant", 16'(bus.grant1), 16'd0);
        chk("clear_no_deny", 16'(bus.deny1), 16'd0);
        chk("full_cleared", 16'(bus.full), 16'd0);
        m_mask = 16'd0;
        step();
        move(1, 4'd3, 1'b0);
        move(2, 4'd15, 1'b0);

        // Simultaneous requests from a fresh priority state
        do_reset();
        both(4'd5, 4'd10);
        move(2, 4'd4, 1'b0);
        both(4'd1, 4'd2);

        // Reset in the middle of an animation aborts without a write
        sb.push_back('{EV_GRANT, 1, 0});
        set_req(1, 1'b1, 4'd15);
        wait_resp(1);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("mid_anim_y", 16'(bus.anim_y), 16'd40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 4; i++) step();
        chk("no_write_after_abort", 16'(bus.wr_en), 16'd0);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_move_arbiter.md
SPRITE_MOVE_ARBITER -- requirements
Module: sprite_move_arbiter

Interface
REQ-001 SHALL have parameter CELL_W, default 10'd160: board cell width in pixels.
REQ-002 SHALL have parameter CELL_H, default 10'd120: board cell height in pixels.
REQ-003 SHALL have parameter STEP_Y, default 10'd40: drop distance in pixels per frame.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse at start of vertical blank.
REQ-007 SHALL have ports req1 / req2, input, 1 each: player 1 / player 2 move request, level, held until grant or deny.
REQ-008 SHALL have ports cell1 / cell2, input, 4 each: target cell; row = [3:2], column = [1:0].
REQ-009 SHALL have port clear, input, 1: empty the board.
REQ-010 SHALL have ports grant1 / grant2 / deny1 / deny2, output, 1 each: one-cycle response pulses.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have ports wr_en (1), wr_addr (4), wr_player (2), output: board memory write, with player code 2'd1 or 2'd2.
REQ-013 SHALL have ports anim_x, anim_y, output, 10 each: falling-sprite position; anim_active, output, 1: sprite visible.
REQ-014 SHALL have port full, output, 1: all 16 cells occupied.

Function
REQ-015 SHALL hold a 16-bit occupancy mask; states IDLE, ANIM, COMMIT.
REQ-016 In IDLE with clear high, SHALL zero the mask next cycle; clear SHALL beat same-cycle requests, which get no response that cycle; clear outside IDLE SHALL be ignored.
REQ-017 In IDLE with one request, SHALL pick that player as winner; with both, SHALL pick per REQ-027/028.
REQ-018 Winner's cell occupied, or full high: SHALL pulse winner's deny next cycle and stay IDLE.
REQ-019 Winner's cell free: SHALL pulse winner's grant next cycle, latch cell/player, enter ANIM.
REQ-020 Loser SHALL get neither grant nor deny; its request stays pending.
REQ-021 On ANIM entry: anim_x = column*CELL_W, anim_y = 0, anim_active = 1, all in the same cycle as grant.
REQ-022 In ANIM, each frame_tick: if anim_y+STEP_Y >= row*CELL_H, SHALL set anim_y = row*CELL_H and enter COMMIT; else anim_y += STEP_Y. Arithmetic SHALL be 10-bit with no overflow for default parameters.
REQ-023 In COMMIT (one cycle): wr_en = 1, wr_addr = latched cell, wr_player = latched player; SHALL set the mask bit and return to IDLE.
REQ-024 anim_active SHALL fall on the cycle after COMMIT; requests SHALL be evaluated again from that cycle.
REQ-025 full SHALL equal the AND of all mask bits, registered with the mask.

Reset
REQ-026 rst SHALL force: state IDLE, mask 0, priority to player 1, all pulses 0, wr_addr 0, wr_player 0, anim_x 0, anim_y 0, anim_active 0, busy 0, full 0; rst in ANIM SHALL abort with no write.

Configuration
REQ-027 With SPRITE_ARB_RR_EN defined, SHALL use round-robin: priority token starts at player 1 and toggles to the other player on each COMMIT.
REQ-028 Without SPRITE_ARB_RR_EN, player 1 SHALL always win simultaneous requests.

Verification
REQ-029 Reset, req1 with cell1=4'b0110 -> grant1 next cycle; anim_x=320, anim_y=0; after 3 frame_ticks anim_y=120 (80 after 2nd tick, clamped at 3rd); wr_en with wr_addr=6, wr_player=1; mask bit 6 set.
REQ-030 req2 with cell2=6 after scenario 1 -> deny2 one cycle; busy stays 0; no wr_en.
REQ-031 req1 and req2 together with distinct free cells, RR_EN defined -> grant1 first; after commit, pending req2 -> grant2. Without the macro and both requests reasserted -> grant1 every time.
REQ-032 cell 0 (row 0) -> first frame_tick commits with anim_y=0.
REQ-033 Fill all 16 cells -> full=1; next request denied; clear in IDLE -> full=0, mask 0.
REQ-034 rst mid-ANIM -> no wr_en; all outputs at reset values next cycle.
